pipe_adder: RTL and testbench



---
 rtl/pipe_adder.sv | 90 +++++++++
 tb/tb_pipe_adder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: LATENCY-stage add/subtract pipeline with valid/ready flow control,
// carry/borrow and signed overflow flags. Define PIPE_ADDER_SAT_EN for unsigned saturation.
module pipe_adder #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic [CNT_W-1:0] res_cnt
);
    // Stage payload layout: {overflow, carry, sum}
    localparam int PW = WIDTH + 2;

    logic             w_advance;
    logic             w_is_sub;
    logic             w_cin_eff;
    logic [WIDTH:0]   w_rhs;
    logic [WIDTH:0]   w_raw;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [PW-1:0]    w_pay;

    logic             r_vld [LATENCY];
    logic [PW-1:0]    r_pay [LATENCY];
    logic [CNT_W-1:0] r_cnt;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // The full result is formed ahead of stage 0; later stages only carry it forward.
    always_comb begin
        w_is_sub  = op[0];
        w_cin_eff = op[1] & cin;
        w_rhs     = {1'b0, b} + {{WIDTH{1'b0}}, w_cin_eff};
        w_raw     = w_is_sub ? ({1'b0, a} - w_rhs) : ({1'b0, a} + w_rhs);
        if (w_is_sub)
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
        else
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
        w_sum = w_raw[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (w_raw[WIDTH])
            w_sum = w_is_sub ? '0 : '1;
`endif
        w_pay = {w_ovf, w_raw[WIDTH], w_sum};
    end

    // Payload only moves behind a valid beat, so bubbles never disturb held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_pay[i] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            if (in_valid)
                r_pay[0] <= w_pay;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1])
                    r_pay[i] <= r_pay[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (out_valid && out_ready)
            r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid                = r_vld[LATENCY-1];
    assign {overflow, carry, sum}   = r_pay[LATENCY-1];
    assign res_cnt                  = r_cnt;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed stimulus against a queue-based timing and
// arithmetic model of pipe_adder (also honours PIPE_ADDER_SAT_EN).
module tb_pipe_adder;
    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    op = 2'b00;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          carry;
    logic          overflow;
    logic [CW-1:0] res_cnt;

    pipe_adder #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow),
        .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W+1:0] pay;
        int           age;
    } beat_t;

    beat_t         q[$];
    logic [W+1:0]  m_last = '0;
    logic [CW-1:0] m_cnt = '0;
    bit            m_init = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_out = 0;
    int            mode = 0;
    bit            m_ov;
    bit            m_adv;
    bit            c_ov;
    logic [W+1:0]  c_pay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from integer values: unsigned range gives carry/borrow,
    // signed range gives overflow.
    function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [1:0] o, input logic c);
        longint ux, uy, sx, sy, ci, full, sres;
        logic cy, ov;
        logic [W-1:0] s;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy = y[W-1] ? uy - (longint'(1) << W) : uy;
        ci = (o[1] && c) ? 1 : 0;
        if (o[0]) begin
            full = ux - uy - ci;
            sres = sx - sy - ci;
            cy   = full < 0;
        end else begin
            full = ux + uy + ci;
            sres = sx + sy + ci;
            cy   = full >= (longint'(1) << W);
        end
        s  = W'(full);
        ov = (sres < -(longint'(1) << (W-1))) || (sres >= (longint'(1) << (W-1)));
`ifdef PIPE_ADDER_SAT_EN
        if (cy)
            s = o[0] ? '0 : '1;
`endif
        return {ov, cy, s};
    endfunction

    // Model: each accepted beat ages on every advancing edge and is presented once
    // its age reaches LAT-1; it leaves on an output handshake.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt  = '0;
            m_last = '0;
            m_init = 1'b1;
        end else begin
            m_ov  = (q.size() > 0) && (q[0].age >= LAT-1);
            m_adv = !m_ov || out_ready;
            if (m_ov && out_ready) begin
                n_out++;
                $display("out %0d: sum=%h carry=%b ovf=%b model=%h res_cnt=%0d",
                         n_out, sum, carry, overflow, q[0].pay, m_cnt + 1'b1);
                m_last = q[0].pay;
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (m_adv)
                foreach (q[i]) q[i].age++;
            if (in_valid && m_adv)
                q.push_back('{calc(a, b, op, cin), 0});
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            c_ov  = (q.size() > 0) && (q[0].age >= LAT-1);
            c_pay = c_ov ? q[0].pay : m_last;
            check("out_valid", 32'(out_valid), 32'(c_ov));
            check("in_ready", 32'(in_ready), 32'(!c_ov || out_ready));
            check("result", 32'({overflow, carry, sum}), 32'(c_pay));
            check("res_cnt", 32'(res_cnt), 32'(m_cnt));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Drivers are always entered just after a rising edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [1:0] o, input logic c);
        bit acc;
        int n = 0;
        a = x; b = y; op = o; cin = c; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: waited %0d cycles, required acceptance", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d beats pending, required 0", q.size());
        end
    endtask

    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [1:0] o, input logic c,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        int n = 0;
        drain();
        send(x, y, o, c);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, 32'(n), 32'(LAT));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_carry"}, 32'(carry), 32'(ec));
        check({name, "_ovf"}, 32'(overflow), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_sum", 32'(sum), 32'(0));
        check("reset_res_cnt", 32'(res_cnt), 32'(0));
        @(posedge clk);
        #1;

        check("pin_add", 32'(calc(8'h12, 8'h34, 2'b00, 1'b0)), 32'({1'b0, 1'b0, 8'h46}));
        check("pin_sub_ovf", 32'(calc(8'h80, 8'h01, 2'b01, 1'b0)), 32'({1'b1, 1'b0, 8'h7F}));
        check("pin_cin_ovf", 32'(calc(8'h7F, 8'h00, 2'b10, 1'b1)), 32'({1'b1, 1'b0, 8'h80}));
        check("pin_sbb", 32'(calc(8'h05, 8'h02, 2'b11, 1'b1)), 32'({1'b0, 1'b0, 8'h02}));

        directed("add_basic", 8'h12, 8'h34, 2'b00, 1'b0, 8'h46, 1'b0, 1'b0);
        check("res_cnt_first", 32'(res_cnt), 32'(1));
`ifdef PIPE_ADDER_SAT_EN
        directed("add_carry", 8'hFF, 8'h01, 2'b00, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed("sub_borrow", 8'h00, 8'h01, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
`else
        directed("add_carry", 8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("sub_borrow", 8'h00, 8'h01, 2'b01, 1'b0, 8'hFF, 1'b1, 1'b0);
`endif
        directed("sub_ovf", 8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed("addc_ovf", 8'h7F, 8'h00, 2'b10, 1'b1, 8'h80, 1'b0, 1'b1);
        directed("subb", 8'h05, 8'h02, 2'b11, 1'b1, 8'h02, 1'b0, 1'b0);
        drain();

        // Ten back-to-back beats with a three-cycle consumer stall mid-stream.
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
            end
            begin
                repeat (4) @(posedge clk);
                #2 mode = 2;
                repeat (3) @(posedge clk);
                #2 mode = 0;
            end
        join
        drain();
        check("stall_res_cnt", 32'(res_cnt), 32'(10));

        // Reset with two beats in flight behind a stalled consumer.
        mode = 2;
        @(posedge clk);
        #1;
        send(8'h11, 8'h22, 2'b00, 1'b0);
        send(8'h33, 8'h44, 2'b01, 1'b0);
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_res_cnt", 32'(res_cnt), 32'(0));
        mode = 0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", 32'(out_valid), 32'(0));
        check("midrst_cnt_after", 32'(res_cnt), 32'(0));

        mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
        end
        mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
